// File: rtl/envelope_gen_pkg.sv
// Shared definitions for the envelope generator: stage codes and a small
// helper used to decode the "running" status from a stage value.
package envelope_gen_pkg;

    typedef logic [2:0] stage_t;

    localparam stage_t ST_IDLE    = 3'd0;
    localparam stage_t ST_ATTACK  = 3'd1;
    localparam stage_t ST_DECAY   = 3'd2;
    localparam stage_t ST_SUSTAIN = 3'd3;
    localparam stage_t ST_RELEASE = 3'd4;

    // Any stage other than IDLE means an envelope is in progress.
    function automatic logic stage_active(input stage_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/envelope_gen_tick.sv
// Step-interval timer for the envelope generator. Emits a one-clk tick every
// (ivl+1) clocks. Clearing restarts the count so the first tick after a clear
// lands ivl+1 clocks later. The tick is ">=" rather than "==" so that a live
// reduction of ivl below the current count still fires promptly instead of
// running the counter all the way around.
module env_tick #(
    parameter int IVL_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IVL_W-1:0] ivl,
    input  logic             clr,
    output logic             tick
);

    logic [IVL_W-1:0] cnt;

    assign tick = (cnt >= ivl);

    // Count up between ticks, restart on tick or on an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator. The gate input is synchronised and edge-detected;
// a five-stage FSM (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE) steps the level by one
// on each tick of a shared interval timer whose period is selected by stage.
module envelope_gen
    import envelope_gen_pkg::*;
#(
    parameter int LEVEL_W = 7,
    parameter int IVL_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gate,
    input  logic [IVL_W-1:0]   a_ivl,
    input  logic [IVL_W-1:0]   d_ivl,
    input  logic [IVL_W-1:0]   r_ivl,
    input  logic [LEVEL_W-1:0] sus_lvl,
    input  logic               retrig,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         stage,
    output logic               running,
    output logic               done
);

    localparam logic [LEVEL_W-1:0] LMAX    = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LMAX_M1 = LMAX - 1'b1;

    logic               gate_s1;
    logic               gate_s2;
    logic               gate_dly;
    logic               gate_rise;
    logic               gate_fall;

    stage_t             stage_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [LEVEL_W-1:0] lvl_dn;
    logic               done_nxt;

    logic [IVL_W-1:0]   act_ivl;
    logic               tick;
    logic               tick_clr;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_s1  <= 1'b0;
            gate_s2  <= 1'b0;
            gate_dly <= 1'b0;
        end else begin
            gate_s1  <= gate;
            gate_s2  <= gate_s1;
            gate_dly <= gate_s2;
        end
    end

    assign gate_rise = gate_s2 & ~gate_dly;
    assign gate_fall = ~gate_s2 & gate_dly;
    assign lvl_dn    = level - 1'b1;

    // Pick the step interval belonging to the current stage.
    always_comb begin
        act_ivl = '0;
        case (stage)
            ST_ATTACK:  act_ivl = a_ivl;
            ST_DECAY:   act_ivl = d_ivl;
            ST_RELEASE: act_ivl = r_ivl;
            default:    act_ivl = '0;
        endcase
    end

    // Every stage entry (including re-entering ATTACK) restarts the timer.
    assign tick_clr = gate_rise | (stage_nxt != stage);

    env_tick #(
        .IVL_W (IVL_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .ivl   (act_ivl),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Next-state logic: gate rise beats everything, gate fall beats a tick.
    always_comb begin
        stage_nxt = stage;
        level_nxt = level;
        done_nxt  = 1'b0;
        if (gate_rise) begin
            stage_nxt = ST_ATTACK;
            level_nxt = retrig ? level : '0;
        end else begin
            case (stage)
                ST_IDLE: begin
                    stage_nxt = ST_IDLE;
                end
                ST_ATTACK: begin
                    if (gate_fall) begin
                        stage_nxt = ST_RELEASE;
                    end else if (tick) begin
                        if (level >= LMAX_M1) begin
                            level_nxt = LMAX;
                            stage_nxt = ST_DECAY;
                        end else begin
                            level_nxt = level + 1'b1;
                        end
                    end
                end
                ST_DECAY: begin
                    if (gate_fall) begin
                        stage_nxt = ST_RELEASE;
                    end else if (sus_lvl >= level) begin
                        stage_nxt = ST_SUSTAIN;
                    end else if (tick) begin
                        level_nxt = lvl_dn;
                        if (lvl_dn == sus_lvl) begin
                            if (sus_lvl == '0) begin
                                stage_nxt = ST_IDLE;
                                done_nxt  = 1'b1;
                            end else begin
                                stage_nxt = ST_SUSTAIN;
                            end
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (gate_fall) begin
                        stage_nxt = ST_RELEASE;
                    end else begin
                        level_nxt = sus_lvl;
                    end
                end
                ST_RELEASE: begin
                    if (level == '0) begin
                        stage_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else if (tick) begin
                        level_nxt = lvl_dn;
                        if (lvl_dn == '0) begin
                            stage_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    stage_nxt = ST_IDLE;
                    level_nxt = '0;
                end
            endcase
        end
    end

    // Stage, level and the one-clk done pulse are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= ST_IDLE;
            level <= '0;
            done  <= 1'b0;
        end else begin
            stage <= stage_nxt;
            level <= level_nxt;
            done  <= done_nxt;
        end
    end

    assign running = stage_active(stage);

endmodule

// File: tb/tb_envelope_gen.sv
// Self-checking bench for envelope_gen. Stimulus code pushes expected
// {level, stage, running, done} snapshots tagged with the cycle at which they
// must appear; a negedge monitor pops and compares them.
module tb_envelope_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gate;
    logic [31:0] a_ivl;
    logic [31:0] d_ivl;
    logic [31:0] r_ivl;
    logic [6:0]  sus_lvl;
    logic        retrig;
    logic [6:0]  level;
    logic [2:0]  stage;
    logic        running;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n;

    int    q_cyc[$];
    string q_tag[$];
    int    q_val[$];
    int    mon_v;
    string mon_t;

    envelope_gen #(
        .LEVEL_W (7),
        .IVL_W   (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gate    (gate),
        .a_ivl   (a_ivl),
        .d_ivl   (d_ivl),
        .r_ivl   (r_ivl),
        .sus_lvl (sus_lvl),
        .retrig  (retrig),
        .level   (level),
        .stage   (stage),
        .running (running),
        .done    (done)
    );

    // Free-running clock and posedge cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", tag, observed, expected);
        end
    endtask

    task automatic expectAt(input int c, input string tag, input int lvl, input int stg,
                            input int run, input int dn);
        q_cyc.push_back(c);
        q_tag.push_back(tag);
        q_val.push_back((dn << 11) | (run << 10) | (stg << 7) | lvl);
    endtask

    task automatic applyStimulus(input logic g, input logic rt, input int a, input int d,
                                 input int r, input int s);
        gate    = g;
        retrig  = rt;
        a_ivl   = a;
        d_ivl   = d;
        r_ivl   = r;
        sus_lvl = s[6:0];
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drainQueue();
        int budget;
        budget = 3000;
        while (q_cyc.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        checkOutput("sb_empty", q_cyc.size(), 0);
        q_cyc.delete();
        q_tag.delete();
        q_val.delete();
    endtask

    task automatic settleIdle();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 64);
        repeat (300) @(negedge clk);
    endtask

    // Reach RELEASE at level 40 with a slow release, then raise the gate with
    // a_ivl=9 and the given retrig; lvl0 is the level expected after the rise.
    task automatic releaseAt40Rise(input logic rt, input int lvl0);
        int b;
        int p;
        @(negedge clk);
        b = cyc;
        p = b + 50;
        expectAt(b + 44, "rel40", 40, 4, 1, 0);
        expectAt(p + 2, "pre_rise", 40, 4, 1, 0);
        expectAt(p + 3, "rise_att", lvl0, 1, 1, 0);
        expectAt(p + 12, "att_hold", lvl0, 1, 1, 0);
        expectAt(p + 13, "att_step", lvl0 + 1, 1, 1, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 1000, 64);
        waitUntil(b + 41);
        applyStimulus(1'b0, 1'b0, 0, 0, 1000, 64);
        waitUntil(p);
        applyStimulus(1'b1, rt, 9, 0, 1000, 64);
        drainQueue();
    endtask

    // Scoreboard monitor: compare every snapshot due at this cycle.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            void'(q_cyc.pop_front());
            mon_t = q_tag.pop_front();
            mon_v = q_val.pop_front();
            checkOutput({mon_t, ".lvl"}, int'(level), mon_v & 127);
            checkOutput({mon_t, ".stg"}, int'(stage), (mon_v >> 7) & 7);
            checkOutput({mon_t, ".run"}, int'(running), (mon_v >> 10) & 1);
            checkOutput({mon_t, ".done"}, int'(done), (mon_v >> 11) & 1);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 64);
        repeat (3) @(negedge clk);
        checkOutput("rst.lvl", int'(level), 0);
        checkOutput("rst.stg", int'(stage), 0);
        checkOutput("rst.run", int'(running), 0);
        checkOutput("rst.done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full attack to 127, decay to 64, sustain.
        n = cyc;
        expectAt(n + 2, "a_idle", 0, 0, 0, 0);
        expectAt(n + 3, "a_start", 0, 1, 1, 0);
        expectAt(n + 4, "a_1", 1, 1, 1, 0);
        expectAt(n + 53, "a_50", 50, 1, 1, 0);
        expectAt(n + 129, "a_126", 126, 1, 1, 0);
        expectAt(n + 130, "d_127", 127, 2, 1, 0);
        expectAt(n + 131, "d_126", 126, 2, 1, 0);
        expectAt(n + 192, "d_65", 65, 2, 1, 0);
        expectAt(n + 193, "s_64", 64, 3, 1, 0);
        expectAt(n + 200, "s_hold", 64, 3, 1, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 64);
        drainQueue();

        // Release from 64 with r_ivl=3.
        @(negedge clk);
        n = cyc;
        expectAt(n + 2, "r_pre", 64, 3, 1, 0);
        expectAt(n + 3, "r_enter", 64, 4, 1, 0);
        expectAt(n + 6, "r_hold", 64, 4, 1, 0);
        expectAt(n + 7, "r_63", 63, 4, 1, 0);
        expectAt(n + 10, "r_63h", 63, 4, 1, 0);
        expectAt(n + 11, "r_62", 62, 4, 1, 0);
        expectAt(n + 258, "r_1", 1, 4, 1, 0);
        expectAt(n + 259, "r_done", 0, 0, 0, 1);
        expectAt(n + 260, "r_after", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 3, 64);
        drainQueue();

        // Gate rise during release at level 40: hard restart, then legato.
        releaseAt40Rise(1'b0, 0);
        settleIdle();
        releaseAt40Rise(1'b1, 40);
        settleIdle();

        // Decay to zero sustain ends the envelope; later gate fall is ignored.
        @(negedge clk);
        n = cyc;
        expectAt(n + 130, "z_127", 127, 2, 1, 0);
        expectAt(n + 131, "z_126", 126, 2, 1, 0);
        expectAt(n + 256, "z_1", 1, 2, 1, 0);
        expectAt(n + 257, "z_done", 0, 0, 0, 1);
        expectAt(n + 258, "z_after", 0, 0, 0, 0);
        expectAt(n + 265, "z_fall", 0, 0, 0, 0);
        expectAt(n + 268, "z_quiet", 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
        waitUntil(n + 262);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
        drainQueue();
        settleIdle();

        // Asynchronous reset mid-attack, gate held high across release.
        @(negedge clk);
        n = cyc;
        expectAt(n + 53, "x_50", 50, 1, 1, 0);
        expectAt(n + 54, "x_rst", 0, 0, 0, 0);
        expectAt(n + 55, "x_rst2", 0, 0, 0, 0);
        expectAt(n + 56, "x_rst3", 0, 0, 0, 0);
        expectAt(n + 58, "x_sync1", 0, 0, 0, 0);
        expectAt(n + 59, "x_sync2", 0, 0, 0, 0);
        expectAt(n + 60, "x_att", 0, 1, 1, 0);
        expectAt(n + 61, "x_att1", 1, 1, 1, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 64);
        waitUntil(n + 53);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        waitUntil(n + 57);
        rst_n = 1'b1;
        drainQueue();
        settleIdle();

        // Gate fall coincident with an attack tick; release at 0 ends at once.
        @(negedge clk);
        n = cyc;
        expectAt(n + 12, "f_att", 0, 1, 1, 0);
        expectAt(n + 13, "f_rel", 0, 4, 1, 0);
        expectAt(n + 14, "f_done", 0, 0, 0, 1);
        expectAt(n + 15, "f_after", 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 9, 0, 0, 64);
        waitUntil(n + 10);
        applyStimulus(1'b0, 1'b0, 9, 0, 0, 64);
        drainQueue();
        settleIdle();

        // Gate rise coincident with a release tick, legato: no step that clk.
        @(negedge clk);
        n = cyc;
        expectAt(n + 22, "g_att", 19, 1, 1, 0);
        expectAt(n + 27, "g_rel", 19, 4, 1, 0);
        expectAt(n + 28, "g_rise", 19, 1, 1, 0);
        expectAt(n + 29, "g_step", 20, 1, 1, 0);
        applyStimulus(1'b1, 1'b1, 0, 0, 0, 64);
        waitUntil(n + 20);
        applyStimulus(1'b0, 1'b1, 0, 0, 4, 64);
        waitUntil(n + 25);
        applyStimulus(1'b1, 1'b1, 0, 0, 4, 64);
        drainQueue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
